// File: rtl/cfg_slave_regs_if.sv
// Configuration register bus between the command-socket master and one slot.
// valid/ready: an enable (cfg_mread_en / cfg_mwrite_en) is held with addr/data stable until cfg_sack rises; the master then drops it and cfg_sack falls.
`timescale 1ns/1ps
interface cfg_slave_regs_if;
  logic        cfg_mread_en;
  logic        cfg_mwrite_en;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data_mwrite;
  logic        cfg_sack;
  logic [31:0] cfg_data_mread;

  modport master (
    output cfg_mread_en, cfg_mwrite_en, cfg_addr, cfg_data_mwrite,
    input  cfg_sack, cfg_data_mread
  );

  modport slave (
    input  cfg_mread_en, cfg_mwrite_en, cfg_addr, cfg_data_mwrite,
    output cfg_sack, cfg_data_mread
  );
endinterface

// File: rtl/cfg_slave_regs.sv
// Responder end of the configuration bus: synchronises the enables, accesses a local
// register bank and answers with a four-phase sack handshake. Address 0 holds sticky errors.
`timescale 1ns/1ps
module cfg_slave_regs #(
  parameter int                      NUM_REGS     = 16,
  parameter logic [NUM_REGS-1:0]     RO_MASK      = '0,
  parameter logic [NUM_REGS*32-1:0]  RESET_VALUES = '0,
  parameter int                      SYNC_STAGES  = 2
) (
  input  logic                     clock,
  input  logic                     n_reset,
  cfg_slave_regs_if.slave          cfg,
  input  logic [NUM_REGS*32-1:0]   reg_status_in,
  output logic [NUM_REGS*32-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_write_strobe,
  output logic                     module_error,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, RELEASE} state_e;
  typedef enum logic [2:0] {K_CONFLICT, K_BADADDR, K_RO_WR, K_ERR_WR, K_ERR_RD, K_WRITE, K_READ} kind_e;

  localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

  state_e                 state_q, state_d;
  kind_e                  kind_q, kind_d, kind_c;
  logic [7:0]             addr_q, addr_d;
  logic                   sack_q, sack_d;
  logic [31:0]            data_q, data_d;
  logic [NUM_REGS-1:0]    strobe_q, strobe_d;
  logic [2:0]             err_q, err_d, err_set, err_clr;
  logic                   module_error_q, module_error_d;
  logic [31:0]            regs_q [NUM_REGS];
  logic [31:0]            regs_d [NUM_REGS];
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
  logic                   rd_s, wr_s, addr_ok, ro_hit;
  logic [31:0]            sel_val;

  assign rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], cfg.cfg_mread_en};
  assign wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], cfg.cfg_mwrite_en};
  assign rd_s      = rd_sync_q[SYNC_STAGES-1];
  assign wr_s      = wr_sync_q[SYNC_STAGES-1];
  assign addr_ok   = {1'b0, cfg.cfg_addr} < NREGS9;

  always_comb begin
    ro_hit = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (cfg.cfg_addr == 8'(i)) ro_hit = RO_MASK[i];
    end
  end

  // First matching rule wins; the order here is the error precedence.
  always_comb begin
    if (rd_s && wr_s)                 kind_c = K_CONFLICT;
    else if (!addr_ok)                kind_c = K_BADADDR;
    else if (wr_s && ro_hit)          kind_c = K_RO_WR;
    else if (wr_s && cfg.cfg_addr == 8'd0) kind_c = K_ERR_WR;
    else if (cfg.cfg_addr == 8'd0)    kind_c = K_ERR_RD;
    else if (wr_s)                    kind_c = K_WRITE;
    else                              kind_c = K_READ;
  end

  // Value of the latched register; RO slots sample the live status at this edge.
  always_comb begin
    sel_val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr_q == 8'(i)) sel_val = RO_MASK[i] ? reg_status_in[32*i +: 32] : regs_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    addr_d   = addr_q;
    sack_d   = sack_q;
    data_d   = data_q;
    strobe_d = '0;
    err_set  = '0;
    err_clr  = '0;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        if (rd_s || wr_s) begin
          state_d = ACCESS;
          kind_d  = kind_c;
          addr_d  = cfg.cfg_addr;
          case (kind_c)
            K_CONFLICT: err_set[1] = 1'b1;
            K_BADADDR:  err_set[0] = 1'b1;
            K_RO_WR:    err_set[2] = 1'b1;
            K_ERR_WR:   err_clr    = cfg.cfg_data_mwrite[2:0];
            K_WRITE: begin
              for (int i = 1; i < NUM_REGS; i++) begin
                if (cfg.cfg_addr == 8'(i)) begin
                  regs_d[i]   = cfg.cfg_data_mwrite;
                  strobe_d[i] = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ACCESS: begin
        state_d = ACK;
        case (kind_q)
          K_CONFLICT:         data_d = '0;
          K_BADADDR:          data_d = '1;
          K_ERR_WR, K_ERR_RD: data_d = {29'd0, err_q};
          default:            data_d = sel_val;
        endcase
      end
      ACK: begin
        state_d = RELEASE;
        sack_d  = 1'b1;
      end
      RELEASE: begin
        if (!rd_s && !wr_s) begin
          state_d = IDLE;
          sack_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A bit set in the same cycle as its clear stays set.
    err_d          = (err_q & ~err_clr) | err_set;
    module_error_d = |err_d;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q        <= IDLE;
      kind_q         <= K_READ;
      addr_q         <= '0;
      sack_q         <= 1'b0;
      data_q         <= '0;
      strobe_q       <= '0;
      err_q          <= '0;
      module_error_q <= 1'b0;
      rd_sync_q      <= '0;
      wr_sync_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUES[32*i +: 32];
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      addr_q         <= addr_d;
      sack_q         <= sack_d;
      data_q         <= data_d;
      strobe_q       <= strobe_d;
      err_q          <= err_d;
      module_error_q <= module_error_d;
      rd_sync_q      <= rd_sync_d;
      wr_sync_q      <= wr_sync_d;
      regs_q         <= regs_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[32*i +: 32] = regs_q[i];
    end
  end

  assign cfg.cfg_sack       = sack_q;
  assign cfg.cfg_data_mread = data_q;
  assign reg_write_strobe   = strobe_q;
  assign module_error       = module_error_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_cfg_slave_regs.sv
// Directed bench for cfg_slave_regs: transaction-level model of the register bank and
// error bits, handshake timing checks per transaction, and an idle-time compare process.
`timescale 1ns/1ps
module tb_cfg_slave_regs;
  localparam int NR = 16;
  localparam logic [NR-1:0]    RO = 16'h0004;
  localparam logic [NR*32-1:0] RV = (512'(32'h1234_5678) << 96) | (512'(32'h5555_0005) << 160);

  logic              clk = 1'b0;
  logic              n_reset;
  logic [NR*32-1:0]  status;
  logic [NR*32-1:0]  reg_out;
  logic [NR-1:0]     strobe;
  logic              module_error;
  logic [1:0]        state_dbg;

  cfg_slave_regs_if bus();

  cfg_slave_regs #(.NUM_REGS(NR), .RO_MASK(RO), .RESET_VALUES(RV), .SYNC_STAGES(2)) dut (
    .clock(clk), .n_reset(n_reset), .cfg(bus.slave), .reg_status_in(status),
    .reg_out(reg_out), .reg_write_strobe(strobe), .module_error(module_error),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sack_rises = 0;
  int ntx = 0;
  logic sack_prev = 1'b0;
  logic chk_en = 1'b0;

  logic [31:0]   m_regs [NR];
  logic [2:0]    m_err;
  logic [NR-1:0] ro_v;
  logic [31:0]   exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = RV[32*i +: 32];
    m_err = '0;
  endtask

  // Spec-level access rules: returns the reply and the register expected to strobe.
  task automatic model(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic [NR-1:0] s);
    int ai;
    ai = int'(a);
    s  = '0;
    if (rd && wr) begin
      m_err[1] = 1'b1; r = 32'h0;
    end else if (ai >= NR) begin
      m_err[0] = 1'b1; r = 32'hFFFF_FFFF;
    end else if (wr && ai != 0 && ro_v[ai]) begin
      m_err[2] = 1'b1; r = status[32*ai +: 32];
    end else if (wr && ai == 0) begin
      m_err = m_err & ~d[2:0]; r = {29'd0, m_err};
    end else if (ai == 0) begin
      r = {29'd0, m_err};
    end else if (wr) begin
      m_regs[ai] = d; s[ai] = 1'b1; r = d;
    end else begin
      r = ro_v[ai] ? status[32*ai +: 32] : m_regs[ai];
    end
  endtask

  // sack rise monitor: every transaction must be acked exactly once
  always @(posedge clk) begin
    if (bus.cfg_sack && !sack_prev) sack_rises++;
    sack_prev = bus.cfg_sack;
  end

  // idle-time compare: outputs must match the model image whenever no transaction is open
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NR; i++)
        chk($sformatf("reg_out[%0d]", i), reg_out[32*i +: 32],
            (i == 0 || ro_v[i]) ? 32'h0 : m_regs[i]);
      chk("module_error", {31'd0, module_error}, {31'd0, |m_err});
      chk("idle_sack", {31'd0, bus.cfg_sack}, 32'h0);
      chk("idle_strobe", {16'd0, strobe}, 32'h0);
    end
  end

  // driver: one full four-phase transaction, then gap idle cycles
  task automatic txn(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] d,
                     input int gap, output logic [31:0] got);
    logic [31:0]   er, pre;
    logic [NR-1:0] es, s_or;
    int            rise, fall, s_cnt;
    @(negedge clk);
    chk_en = 1'b0;
    model(rd, wr, a, d, er, es);
    exp_q.push_back(er);
    ntx++;
    bus.cfg_addr = a; bus.cfg_data_mwrite = d;
    bus.cfg_mread_en = rd; bus.cfg_mwrite_en = wr;
    rise = 0; fall = 0; s_or = '0; s_cnt = 0; pre = 32'h0;
    for (int e = 1; e <= 20 && rise == 0; e++) begin
      @(posedge clk); #1;
      if (strobe != '0) begin s_or |= strobe; s_cnt++; end
      if (bus.cfg_sack) rise = e; else pre = bus.cfg_data_mread;
    end
    chk("sack_rise_latency", rise, 32'd5);
    got = bus.cfg_data_mread;
    chk("reply_vs_model", got, exp_q.pop_front());
    chk("data_before_sack", pre, er);
    @(negedge clk);
    bus.cfg_mread_en = 1'b0; bus.cfg_mwrite_en = 1'b0;
    for (int e = 1; e <= 20 && fall == 0; e++) begin
      @(posedge clk); #1;
      if (strobe != '0) begin s_or |= strobe; s_cnt++; end
      if (!bus.cfg_sack) fall = e;
    end
    chk("sack_fall_latency", fall, 32'd3);
    chk("data_hold_after_sack", bus.cfg_data_mread, er);
    chk("strobe_mask", {16'd0, s_or}, {16'd0, es});
    chk("strobe_cycles", s_cnt, (es != '0) ? 32'd1 : 32'd0);
    repeat (gap) @(posedge clk);
    chk_en = 1'b1;
  endtask

  logic [31:0] got;
  bit          b_rd [10] = '{0, 1, 0, 1, 1, 0, 1, 1, 0, 1};
  logic [7:0]  b_a  [10] = '{8'd1, 8'd1, 8'd7, 8'd7, 8'd2, 8'd15, 8'd15, 8'd3, 8'd3, 8'd0};
  logic [31:0] b_d  [10] = '{32'h0000_0101, 32'h0, 32'hCAFE_F00D, 32'h0, 32'h0,
                             32'hFFFF_0000, 32'h0, 32'h0, 32'h0BAD_0003, 32'h0};

  initial begin
    ro_v = RO;
    for (int i = 0; i < NR; i++) status[32*i +: 32] = 32'hC000_0000 + 32'(i);
    status[64 +: 32] = 32'h0000_A5A5;
    model_reset();
    bus.cfg_mread_en = 1'b0; bus.cfg_mwrite_en = 1'b0;
    bus.cfg_addr = '0; bus.cfg_data_mwrite = '0;
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); n_reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_sack", {31'd0, bus.cfg_sack}, 32'h0);
    chk("rst_data", bus.cfg_data_mread, 32'h0);
    chk("rst_strobe", {16'd0, strobe}, 32'h0);
    chk("rst_error", {31'd0, module_error}, 32'h0);
    chk("rst_reg3", reg_out[96 +: 32], 32'h1234_5678);
    chk("rst_ro_slice", reg_out[64 +: 32], 32'h0);
    chk_en = 1'b1;

    txn(1, 0, 8'd3, 32'h0, 2, got);             chk("pin_read3", got, 32'h1234_5678);
    txn(0, 1, 8'd5, 32'hDEAD_BEEF, 2, got);     chk("pin_write5", got, 32'hDEAD_BEEF);
    chk("pin_reg_out5", reg_out[160 +: 32], 32'hDEAD_BEEF);
    txn(1, 0, 8'd5, 32'h0, 2, got);             chk("pin_read5", got, 32'hDEAD_BEEF);
    txn(1, 0, 8'h20, 32'h0, 2, got);            chk("pin_badaddr", got, 32'hFFFF_FFFF);
    chk("pin_err_set", {31'd0, module_error}, 32'h1);
    txn(1, 0, 8'd0, 32'h0, 2, got);             chk("pin_read_err", got, 32'h1);
    txn(0, 1, 8'd0, 32'h1, 2, got);             chk("pin_w1c", got, 32'h0);
    chk("pin_err_clr", {31'd0, module_error}, 32'h0);
    txn(0, 1, 8'd2, 32'h1, 2, got);             chk("pin_ro_write", got, 32'h0000_A5A5);
    chk("pin_ro_err", {31'd0, module_error}, 32'h1);
    txn(1, 1, 8'd4, 32'h9, 2, got);             chk("pin_conflict", got, 32'h0);
    txn(1, 0, 8'd0, 32'h0, 2, got);             chk("pin_err_bits", got, 32'h6);

    // reset while the write is in ACCESS
    @(negedge clk);
    chk_en = 1'b0;
    bus.cfg_addr = 8'd5; bus.cfg_data_mwrite = 32'h1111_2222; bus.cfg_mwrite_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("rstmid_strobe", {16'd0, strobe}, 32'h0);
    chk("rstmid_sack", {31'd0, bus.cfg_sack}, 32'h0);
    chk("rstmid_reg5", reg_out[160 +: 32], 32'h5555_0005);
    chk("rstmid_error", {31'd0, module_error}, 32'h0);
    bus.cfg_mwrite_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); n_reset = 1'b1;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;

    for (int k = 0; k < 10; k++) txn(b_rd[k], !b_rd[k], b_a[k], b_d[k], 2, got);
    chk("b2b_last_read_err", got, 32'h0);
    chk("b2b_reg7", reg_out[224 +: 32], 32'hCAFE_F00D);

    repeat (4) @(posedge clk);
    chk("sack_rise_count", sack_rises, ntx);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 ns");
    $fatal(1, "timeout");
  end
endmodule
